router_out_arb: RTL and testbench
=================================

ROUTER_OUT_ARB -- requirements
Module: router_out_arb

Interface
REQ-001 Parameter N_PORTS, default 5, SHALL set the number of requesters: index 0 top, 1 bottom, 2 left, 3 right, 4 ip.
REQ-002 Parameter REQ_MASK, default 5'b11111, SHALL exclude a requester from arbitration when its bit is 0 (the ip output port uses 5'b01111).
REQ-003 Parameter MAX_STALL, default 255, SHALL set the mid-packet upstream stall limit in cycles.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 nreset  input  1  SHALL be the reset, synchronous and active-high: 1 at a rising clk edge resets.
REQ-006 req  input  N_PORTS  SHALL be the per-requester head-flit-present flags (inverse of FIFO empty).
REQ-007 head_last  input  N_PORTS  SHALL be the Last bit (bit DATA_WIDTH) of each FIFO head entry.
REQ-008 ready  input  1  SHALL be the downstream neighbour's Ready for this output port.
REQ-009 rd_en  output  N_PORTS  SHALL be the one-hot FIFO pop strobes; at most one bit high.
REQ-010 grant  output  N_PORTS  SHALL be the registered one-hot owner of the port; zero when idle.
REQ-011 sel  output  3  SHALL be the binary index of grant, 0 when idle; used as the data-mux select.
REQ-012 busy  output  1  SHALL be high when the arbiter is in state LOCK.
REQ-013 flit_cnt  output  8  SHALL be the number of flits popped in the current or most recent packet.
REQ-014 stall_err  output  1  SHALL be the sticky mid-packet stall error flag.

Function
REQ-015 The arbiter SHALL have two states, IDLE and LOCK, plus a registered round-robin pointer ptr (0..N_PORTS-1).
REQ-016 In IDLE with no masked req bit set, the arbiter SHALL hold grant=0, rd_en=0, busy=0, and ptr unchanged.
REQ-017 In IDLE with any masked req set at edge t, it SHALL register grant to the first set index scanning ascending from ptr with wrap at N_PORTS-1, and enter LOCK at t; grant is visible in the cycle after t.
REQ-018 On the same edge as a new grant, flit_cnt SHALL clear to 0 and the stall counter SHALL clear to 0.
REQ-019 In LOCK, rd_en[g] SHALL be the combinational AND of grant[g], req[g] and ready; all other rd_en bits are 0.
REQ-020 In LOCK, req and head_last of non-granted indices SHALL be ignored; no packet interleaving.
REQ-021 Each rd_en pulse SHALL increment flit_cnt by 1, saturating at 255.
REQ-022 An rd_en pulse with head_last[g]=1 SHALL, at that edge, return the arbiter to IDLE, clear grant, and set ptr to (g+1) mod N_PORTS; flit_cnt holds its final value.
REQ-023 The minimum gap between the last flit of one packet and the first flit of the next SHALL be one idle cycle (the arbitration cycle).
REQ-024 head_last SHALL be ignored when no rd_en is asserted for that index.
REQ-025 In LOCK with req[g]=0, the stall counter SHALL increment each cycle, saturating at MAX_STALL.
REQ-026 The stall counter SHALL clear on any rd_en and SHALL NOT count cycles where req[g]=1 and ready=0.
REQ-027 When the stall counter reaches MAX_STALL, stall_err SHALL set and remain 1 until reset; the lock SHALL NOT be released.
REQ-028 A single-flit packet (head_last=1 on the first pop) SHALL be handled as in REQ-022.

Reset
REQ-029 Reset SHALL force state=IDLE, ptr=0, grant=0, sel=0, busy=0, flit_cnt=0, stall counter=0, and stall_err=0.
REQ-030 rd_en SHALL be 0 in any cycle where nreset=1.
REQ-031 Reset mid-packet SHALL abandon the lock with no further pops; the packet remnant in the FIFO is re-arbitrated as a new packet.

Structure
REQ-032 Package noc_pkg SHALL hold N_PORTS, the port index enum (TOP, BOTTOM, LEFT, RIGHT, IP), and the arbiter state typedef.
REQ-033 The round-robin priority pick SHALL be one combinational sub-module, rr_pick (inputs: masked req, ptr; outputs: one-hot winner, valid).

Verification
REQ-034 req=5'b00101 in IDLE after reset, ready=1 -> grant=5'b00001 the next cycle; a 3-flit packet pops on 3 consecutive cycles; then IDLE, ptr=1, flit_cnt=3.
REQ-035 All five req bits held high with 1-flit packets, REQ_MASK=5'b11111 -> grant sequence 0,1,2,3,4,0 with one idle cycle between packets.
REQ-036 ready low for 4 cycles mid-packet -> no rd_en, grant unchanged, stall_err stays 0; pops resume on the first cycle ready=1.
REQ-037 MAX_STALL=8 and granted req low for 8 cycles mid-packet -> stall_err=1, busy stays 1; after req returns, pops continue and stall_err stays 1.
REQ-038 REQ_MASK=5'b01111 with only req[4]=1 -> grant stays 0 and no rd_en for 20 cycles.
REQ-039 nreset=1 on the 2nd flit of a 4-flit packet -> next cycle grant=0, ptr=0, flit_cnt=0, no rd_en; re-arbitration starts after nreset drops.

Source files
------------

// File: rtl/router_out_arb_pkg.sv
// Shared types and constants for the NoC output-port arbiter.
// Holds the port index enum, the arbiter state type and a one-hot to index helper.
package noc_pkg;

   localparam int N_PORTS = 5;
   localparam int SEL_W   = 3;

   typedef enum logic [2:0] {
      TOP    = 3'd0,
      BOTTOM = 3'd1,
      LEFT   = 3'd2,
      RIGHT  = 3'd3,
      IP     = 3'd4
   } port_idx_e;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

   function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [7:0] oh);
      logic [SEL_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) idx = idx | SEL_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/router_out_arb_if.sv
// Request/grant bundle between the input FIFOs plus downstream Ready and the output arbiter.
// master = FIFO/neighbour side, slave = arbiter.
interface router_out_arb_if #(
   parameter int N_PORTS = noc_pkg::N_PORTS
);
   import noc_pkg::*;

   logic [N_PORTS-1:0] req;
   logic [N_PORTS-1:0] head_last;
   logic               ready;
   logic [N_PORTS-1:0] rd_en;
   logic [N_PORTS-1:0] grant;
   logic [SEL_W-1:0]   sel;
   logic               busy;
   logic [7:0]         flit_cnt;
   logic               stall_err;

   modport master (
      output req, head_last, ready,
      input  rd_en, grant, sel, busy, flit_cnt, stall_err
   );

   modport slave (
      input  req, head_last, ready,
      output rd_en, grant, sel, busy, flit_cnt, stall_err
   );

endinterface

// File: rtl/router_out_arb_rr_pick.sv
// Round-robin priority pick: first set request scanning upward from ptr, wrapping at N_PORTS-1.
module rr_pick
   import noc_pkg::*;
#(
   parameter int N_PORTS = noc_pkg::N_PORTS
) (
   input  logic [N_PORTS-1:0] i_req,
   input  logic [SEL_W-1:0]   i_ptr,
   output logic [N_PORTS-1:0] o_winner,
   output logic               o_valid
);

   logic [SEL_W-1:0] w_idx;

   always_comb begin
      o_winner = '0;
      o_valid  = 1'b0;
      w_idx    = '0;
      for (int k = 0; k < N_PORTS; k++) begin
         w_idx = SEL_W'((int'(i_ptr) + k) % N_PORTS);
         if (!o_valid && i_req[w_idx]) begin
            o_winner[w_idx] = 1'b1;
            o_valid         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/router_out_arb.sv
// Wormhole output-port arbiter: round-robin grant, packet lock until the Last flit pops,
// and a sticky error when the owning FIFO runs dry mid-packet for too long.
//
//  state | meaning
//  IDLE  | no owner; arbitrate among masked requests each cycle
//  LOCK  | port owned by grant; pop on req&ready until a Last flit leaves
module router_out_arb
   import noc_pkg::*;
#(
   parameter int                 N_PORTS   = noc_pkg::N_PORTS,
   parameter logic [N_PORTS-1:0] REQ_MASK  = '1,
   parameter int                 MAX_STALL = 255
) (
   input  logic                    clk,
   input  logic                    nreset,
   router_out_arb_if.slave         bus
);

   localparam int                 STALL_W   = $clog2(MAX_STALL + 1);
   localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(MAX_STALL);

   arb_state_e          r_state;
   arb_state_e          w_state_nxt;
   logic [N_PORTS-1:0]  r_grant;
   logic [SEL_W-1:0]    r_sel;
   logic [SEL_W-1:0]    r_ptr;
   logic [7:0]          r_flit_cnt;
   logic [STALL_W-1:0]  r_stall_cnt;
   logic [STALL_W-1:0]  w_stall_nxt;
   logic                r_stall_err;

   logic [N_PORTS-1:0]  w_mreq;
   logic [N_PORTS-1:0]  w_winner;
   logic                w_valid;
   logic [N_PORTS-1:0]  w_rd_en;
   logic                w_busy;
   logic                w_pop;
   logic                w_last;
   logic                w_release;
   logic                w_new_grant;
   logic                w_req_g;

   assign w_mreq = bus.req & REQ_MASK;

   rr_pick #(.N_PORTS(N_PORTS)) u_pick (
      .i_req    (w_mreq),
      .i_ptr    (r_ptr),
      .o_winner (w_winner),
      .o_valid  (w_valid)
   );

   always_ff @(posedge clk) begin
      if (nreset) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_valid)   w_state_nxt = LOCK;
         LOCK:    if (w_release) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Pops are gated by reset so a mid-packet reset never drains another flit.
   always_comb begin
      w_rd_en = '0;
      w_busy  = 1'b0;
      if (r_state == LOCK) begin
         w_busy = 1'b1;
         if (!nreset) w_rd_en = r_grant & bus.req & {N_PORTS{bus.ready}};
      end
   end

   assign w_pop       = |w_rd_en;
   assign w_last      = |(w_rd_en & bus.head_last);
   assign w_release   = w_pop & w_last;
   assign w_new_grant = (r_state == IDLE) & w_valid;
   assign w_req_g     = |(r_grant & bus.req);

   // Only an empty owner FIFO counts as a stall; backpressure from ready does not.
   always_comb begin
      w_stall_nxt = r_stall_cnt;
      if (w_new_grant || w_pop)
         w_stall_nxt = '0;
      else if ((r_state == LOCK) && !w_req_g && (r_stall_cnt != STALL_MAX))
         w_stall_nxt = r_stall_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (nreset) begin
         r_grant     <= '0;
         r_sel       <= '0;
         r_ptr       <= '0;
         r_flit_cnt  <= '0;
         r_stall_cnt <= '0;
         r_stall_err <= 1'b0;
      end else begin
         r_stall_cnt <= w_stall_nxt;
         if ((r_state == LOCK) && (w_stall_nxt == STALL_MAX))
            r_stall_err <= 1'b1;
         if (w_new_grant) begin
            r_grant    <= w_winner;
            r_sel      <= onehot_to_idx(8'(w_winner));
            r_flit_cnt <= '0;
         end else if (w_pop) begin
            if (r_flit_cnt != 8'hFF) r_flit_cnt <= r_flit_cnt + 8'd1;
            if (w_last) begin
               r_grant <= '0;
               r_sel   <= '0;
               r_ptr   <= (r_sel == SEL_W'(N_PORTS - 1)) ? '0 : r_sel + 1'b1;
            end
         end
      end
   end

   assign bus.rd_en     = w_rd_en;
   assign bus.grant     = r_grant;
   assign bus.sel       = r_sel;
   assign bus.busy      = w_busy;
   assign bus.flit_cnt  = r_flit_cnt;
   assign bus.stall_err = r_stall_err;

endmodule

// File: tb/tb_router_out_arb.sv
// Bench for router_out_arb: two instances (full mask and ip-port mask, MAX_STALL=8)
// compared every cycle against a packet-level reference model, directed then random.
module tb_router_out_arb;

   localparam int NP        = 5;
   localparam int MAXS      = 8;

   logic       clk = 1'b0;
   logic       nreset;
   logic [4:0] t_req;
   logic [4:0] t_last;
   logic       t_ready;

   int n_checks = 0;
   int n_fail   = 0;

   int m_owner [2];
   int m_ptr   [2];
   int m_cnt   [2];
   int m_stall [2];
   bit m_err   [2];

   router_out_arb_if #(.N_PORTS(NP)) if_a ();
   router_out_arb_if #(.N_PORTS(NP)) if_b ();

   assign if_a.req       = t_req;
   assign if_a.head_last = t_last;
   assign if_a.ready     = t_ready;
   assign if_b.req       = t_req;
   assign if_b.head_last = t_last;
   assign if_b.ready     = t_ready;

   router_out_arb #(.N_PORTS(NP), .REQ_MASK(5'b11111), .MAX_STALL(MAXS)) u_dut_all (
      .clk    (clk),
      .nreset (nreset),
      .bus    (if_a.slave)
   );

   router_out_arb #(.N_PORTS(NP), .REQ_MASK(5'b01111), .MAX_STALL(MAXS)) u_dut_ip (
      .clk    (clk),
      .nreset (nreset),
      .bus    (if_b.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] mask_of(input int k);
      return (k == 0) ? 5'b11111 : 5'b01111;
   endfunction

   function automatic bit bit_at(input logic [4:0] v, input int i);
      return |((v >> i) & 5'd1);
   endfunction

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset(input int k);
      m_owner[k] = -1;
      m_ptr[k]   = 0;
      m_cnt[k]   = 0;
      m_stall[k] = 0;
      m_err[k]   = 1'b0;
   endtask

   task automatic model_edge(input int k);
      logic [4:0] mreq;
      int         idx;
      if (nreset) begin
         model_reset(k);
      end else if (m_owner[k] < 0) begin
         mreq = t_req & mask_of(k);
         for (int j = 0; j < NP; j++) begin
            idx = (m_ptr[k] + j) % NP;
            if (m_owner[k] < 0 && bit_at(mreq, idx)) begin
               m_owner[k] = idx;
               m_cnt[k]   = 0;
               m_stall[k] = 0;
            end
         end
      end else if (bit_at(t_req, m_owner[k]) && t_ready) begin
         if (m_cnt[k] < 255) m_cnt[k]++;
         m_stall[k] = 0;
         if (bit_at(t_last, m_owner[k])) begin
            m_ptr[k]   = (m_owner[k] + 1) % NP;
            m_owner[k] = -1;
         end
      end else if (!bit_at(t_req, m_owner[k])) begin
         if (m_stall[k] < MAXS) m_stall[k]++;
         if (m_stall[k] == MAXS) m_err[k] = 1'b1;
      end
   endtask

   task automatic check_inst(input int k, input logic [4:0] rd, input logic [4:0] gr,
                             input logic [2:0] sl, input logic bz, input logic [7:0] fc,
                             input logic se);
      int e_grant;
      int e_rd;
      e_grant = (m_owner[k] < 0) ? 0 : (1 << m_owner[k]);
      e_rd    = 0;
      if (!nreset && m_owner[k] >= 0 && bit_at(t_req, m_owner[k]) && t_ready)
         e_rd = 1 << m_owner[k];
      chk_eq($sformatf("i%0d_rd_en", k),     32'(rd), e_rd);
      chk_eq($sformatf("i%0d_grant", k),     32'(gr), e_grant);
      chk_eq($sformatf("i%0d_sel", k),       32'(sl), (m_owner[k] < 0) ? 0 : m_owner[k]);
      chk_eq($sformatf("i%0d_busy", k),      32'(bz), (m_owner[k] >= 0) ? 1 : 0);
      chk_eq($sformatf("i%0d_flit_cnt", k),  32'(fc), m_cnt[k]);
      chk_eq($sformatf("i%0d_stall_err", k), 32'(se), 32'(m_err[k]));
   endtask

   task automatic step(input logic [4:0] rq, input logic [4:0] hl, input logic rdy, input logic rst);
      t_req   = rq;
      t_last  = hl;
      t_ready = rdy;
      nreset  = rst;
      @(negedge clk);
      check_inst(0, if_a.rd_en, if_a.grant, if_a.sel, if_a.busy, if_a.flit_cnt, if_a.stall_err);
      check_inst(1, if_b.rd_en, if_b.grant, if_b.sel, if_b.busy, if_b.flit_cnt, if_b.stall_err);
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
   endtask

   initial begin
      logic [4:0] rq;
      logic [4:0] hl;
      logic       rdy;
      logic       rst;
      bit         sparse;

      t_req   = '0;
      t_last  = '0;
      t_ready = 1'b1;
      nreset  = 1'b1;
      model_reset(0);
      model_reset(1);
      @(posedge clk);
      #1;

      step(5'b0, 5'b0, 1'b1, 1'b1);
      step(5'b0, 5'b0, 1'b1, 1'b0);

      // 3-flit packet from port 0, then ptr must favour port 1
      step(5'b00101, 5'b0, 1'b1, 1'b0);
      chk_eq("r034_grant", 32'(if_a.grant), 32'b00001);
      step(5'b00101, 5'b0, 1'b1, 1'b0);
      step(5'b00101, 5'b0, 1'b1, 1'b0);
      step(5'b00101, 5'b00001, 1'b1, 1'b0);
      chk_eq("r034_busy", 32'(if_a.busy), 0);
      chk_eq("r034_flit_cnt", 32'(if_a.flit_cnt), 3);
      step(5'b00011, 5'b0, 1'b1, 1'b0);
      chk_eq("r034_ptr1", 32'(if_a.grant), 32'b00010);
      step(5'b00011, 5'b00010, 1'b1, 1'b0);

      // all requesting single-flit packets
      for (int i = 0; i < 12; i++) step(5'h1F, 5'h1F, 1'b1, 1'b0);
      step(5'b0, 5'b0, 1'b1, 1'b0);

      // downstream backpressure mid-packet
      step(5'b00100, 5'b0, 1'b1, 1'b0);
      step(5'b00100, 5'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(5'b00100, 5'b0, 1'b0, 1'b0);
      chk_eq("r036_grant", 32'(if_a.grant), 32'b00100);
      chk_eq("r036_stall_err", 32'(if_a.stall_err), 0);
      step(5'b00100, 5'b00100, 1'b1, 1'b0);

      // owner FIFO empty for MAX_STALL cycles
      step(5'b01000, 5'b0, 1'b1, 1'b0);
      step(5'b01000, 5'b0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) step(5'b0, 5'b0, 1'b1, 1'b0);
      chk_eq("r037_stall_err", 32'(if_a.stall_err), 1);
      chk_eq("r037_busy", 32'(if_a.busy), 1);
      step(5'b01000, 5'b0, 1'b1, 1'b0);
      step(5'b01000, 5'b01000, 1'b1, 1'b0);
      chk_eq("r037_err_sticky", 32'(if_a.stall_err), 1);

      // masked ip requester never wins on the ip output port
      step(5'b0, 5'b0, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) step(5'b10000, 5'b0, 1'b1, 1'b0);
      chk_eq("r038_grant", 32'(if_b.grant), 0);

      // reset during the 2nd flit of a packet
      step(5'b0, 5'b0, 1'b1, 1'b1);
      step(5'b00010, 5'b0, 1'b1, 1'b0);
      step(5'b00010, 5'b0, 1'b1, 1'b0);
      step(5'b00010, 5'b0, 1'b1, 1'b1);
      chk_eq("r039_grant", 32'(if_a.grant), 0);
      chk_eq("r039_flit_cnt", 32'(if_a.flit_cnt), 0);
      step(5'b00011, 5'b0, 1'b1, 1'b0);
      chk_eq("r039_ptr0", 32'(if_a.grant), 32'b00001);
      step(5'b00011, 5'b00001, 1'b1, 1'b0);

      sparse = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 250 == 0) sparse = ~sparse;
         if (sparse) rq = 5'($urandom & $urandom & $urandom);
         else        rq = 5'($urandom);
         hl  = 5'($urandom & $urandom);
         rdy = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 299) == 0);
         step(rq, hl, rdy, rst);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
